lfu_counter_bank: RTL and testbench

Per-way access-frequency counters for the LFU replacement logic, with periodic aging and a sequential least-frequently-used victim search. Sits directly downstream of the periodic tick generator: each one-cycle `tick` pulse halves every counter so stale popularity decays. The cache controller reports hits and fills here and requests a victim way on a miss.

---
 rtl/lfu_counter_bank.sv | 139 +++++++++++++
 tb/tb_lfu_counter_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfu_counter_bank.sv
// Per-way LFU access-frequency counters with tick-driven halving and a
// sequential lowest-count victim search (one way visited per cycle).
//
// Handshake: victim_req is sampled only while busy=0; a request seen while
// busy=1 is dropped. victim_valid pulses for one cycle when victim_way is
// updated, and victim_way holds until the next result.
module lfu_counter_bank #(
    parameter int WAYS  = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(WAYS)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             tick,
    input  logic             access_valid,
    input  logic [IDX_W-1:0] access_way,
    input  logic             access_fill,
    input  logic             victim_req,
    output logic             busy,
    output logic             victim_valid,
    output logic [IDX_W-1:0] victim_way,
    input  logic [IDX_W-1:0] rd_way,
    output logic [CNT_W-1:0] rd_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WAYS - 1);

    logic [CNT_W-1:0] cnt_q [WAYS];
    logic [CNT_W-1:0] cnt_d [WAYS];
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0] victim_way_q, victim_way_d;
    logic [CNT_W-1:0] scan_cnt;
    logic             scan_less;

    // Way decode by equality, so an out-of-range access_way matches no counter.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            cnt_d[w] = cnt_q[w];
            if (access_valid && (access_way == IDX_W'(w))) begin
                if (access_fill) begin
                    cnt_d[w] = CNT_W'(1);
                end else if (tick) begin
                    cnt_d[w] = (cnt_q[w] >> 1) + CNT_W'(1);
                end else if (cnt_q[w] != CNT_MAX) begin
                    cnt_d[w] = cnt_q[w] + CNT_W'(1);
                end
            end else if (tick) begin
                cnt_d[w] = cnt_q[w] >> 1;
            end
        end
    end

    always_comb begin
        scan_cnt = '0;
        rd_count = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                scan_cnt = cnt_q[w];
            end
            if (rd_way == IDX_W'(w)) begin
                rd_count = cnt_q[w];
            end
        end
    end

    assign scan_less = (scan_cnt < best_cnt_q);

    // Strictly-less replacement keeps the lowest index on ties.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_idx_d   = best_idx_q;
        best_cnt_d   = best_cnt_q;
        victim_way_d = victim_way_q;
        case (state_q)
            ST_IDLE: begin
                if (victim_req) begin
                    best_idx_d = '0;
                    best_cnt_d = cnt_q[0];
                    idx_d      = IDX_W'(1);
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_less) begin
                    best_idx_d = idx_q;
                    best_cnt_d = scan_cnt;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    victim_way_d = scan_less ? idx_q : best_idx_q;
                    idx_d        = '0;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                cnt_q[w] <= '0;
            end
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            best_idx_q   <= '0;
            best_cnt_q   <= '0;
            victim_way_q <= '0;
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                cnt_q[w] <= cnt_d[w];
            end
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_idx_q   <= best_idx_d;
            best_cnt_q   <= best_cnt_d;
            victim_way_q <= victim_way_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign victim_valid = (state_q == ST_DONE);
    assign victim_way   = victim_way_q;

endmodule

// File: tb/tb_lfu_counter_bank.sv
// Bench for lfu_counter_bank: cycle-level reference model of counters and
// search, with a queue of expected victim ways popped on each victim_valid.
module tb_lfu_counter_bank;

    localparam int WAYS  = 4;
    localparam int CNT_W = 8;
    localparam int IDX_W = 2;
    localparam int CMAX  = 255;

    logic             clock = 1'b0;
    logic             rst;
    logic             tick;
    logic             access_valid;
    logic [IDX_W-1:0] access_way;
    logic             access_fill;
    logic             victim_req;
    logic             busy;
    logic             victim_valid;
    logic [IDX_W-1:0] victim_way;
    logic [IDX_W-1:0] rd_way;
    logic [CNT_W-1:0] rd_count;

    lfu_counter_bank #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .rst          (rst),
        .tick         (tick),
        .access_valid (access_valid),
        .access_way   (access_way),
        .access_fill  (access_fill),
        .victim_req   (victim_req),
        .busy         (busy),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .rd_way       (rd_way),
        .rd_count     (rd_count)
    );

    always #5 clock = ~clock;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [IDX_W-1:0] exp_q[$];
    int               mcnt [WAYS];
    int               mstate, midx, mbest_idx, mbest_cnt;
    int               cyc, pulse_cnt, last_valid_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++) mcnt[w] = 0;
        mstate    = 0;
        midx      = 0;
        mbest_idx = 0;
        mbest_cnt = 0;
    endtask

    // One cycle: observe outputs, drive inputs, advance model, cross posedge.
    task automatic step(input logic t, input logic av, input logic [IDX_W-1:0] aw,
                        input logic af, input logic rq, input logic r);
        check("busy", {31'd0, busy}, (mstate != 0) ? 32'd1 : 32'd0);
        check("victim_valid", {31'd0, victim_valid}, (mstate == 2) ? 32'd1 : 32'd0);
        if (victim_valid === 1'b1) begin
            pulse_cnt++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) check("victim_unexpected", {31'd0, victim_valid}, 32'd0);
            else check("victim_way", {30'd0, victim_way}, {30'd0, exp_q.pop_front()});
        end
        tick = t; access_valid = av; access_way = aw; access_fill = af;
        victim_req = rq; rst = r;
        if (r) begin
            model_reset();
        end else begin
            case (mstate)
                0: if (rq) begin
                    mbest_idx = 0; mbest_cnt = mcnt[0]; midx = 1; mstate = 1;
                end
                1: begin
                    if (mcnt[midx] < mbest_cnt) begin
                        mbest_idx = midx; mbest_cnt = mcnt[midx];
                    end
                    if (midx == WAYS - 1) begin
                        exp_q.push_back(IDX_W'(mbest_idx));
                        midx = 0; mstate = 2;
                    end else begin
                        midx++;
                    end
                end
                default: mstate = 0;
            endcase
            for (int w = 0; w < WAYS; w++) begin
                if (av && aw == IDX_W'(w)) begin
                    if (af) mcnt[w] = 1;
                    else if (t) mcnt[w] = (mcnt[w] >> 1) + 1;
                    else if (mcnt[w] < CMAX) mcnt[w] = mcnt[w] + 1;
                end else if (t) begin
                    mcnt[w] = mcnt[w] >> 1;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hits(input logic [IDX_W-1:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_counts(input string tag);
        for (int w = 0; w < WAYS; w++) begin
            rd_way = IDX_W'(w);
            #1;
            check(tag, {24'd0, rd_count}, mcnt[w]);
        end
    endtask

    task automatic read_const(input string tag, input logic [IDX_W-1:0] w, input int exp);
        rd_way = w;
        #1;
        check(tag, {24'd0, rd_count}, exp);
    endtask

    task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
        do_reset();
        hits(2'd0, c0);
        hits(2'd1, c1);
        hits(2'd2, c2);
        hits(2'd3, c3);
    endtask

    task automatic search(input string tag, input int exp_way);
        int c0, p0;
        c0 = cyc;
        p0 = pulse_cnt;
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check({tag, "_latency"}, last_valid_cyc - c0, WAYS);
        check({tag, "_pulses"}, pulse_cnt - p0, 1);
        check({tag, "_way"}, {30'd0, victim_way}, exp_way);
    endtask

    initial begin
        int c0, p0;
        rst = 1'b1; tick = 1'b0; access_valid = 1'b0; access_way = '0;
        access_fill = 1'b0; victim_req = 1'b0; rd_way = '0;
        cyc = 0; pulse_cnt = 0; last_valid_cyc = -1;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);

        check("reset_busy", {31'd0, busy}, 0);
        check("reset_valid", {31'd0, victim_valid}, 0);
        check("reset_victim_way", {30'd0, victim_way}, 0);
        for (int w = 0; w < WAYS; w++) read_const("reset_count", IDX_W'(w), 0);

        // Hits and tie-breaking toward the lowest index.
        hits(2'd2, 3);
        hits(2'd1, 1);
        read_const("hit_way2", 2'd2, 3);
        read_const("hit_way1", 2'd1, 1);
        read_const("hit_way0", 2'd0, 0);
        read_const("hit_way3", 2'd3, 0);
        search("tie", 0);

        // Saturation and aging.
        do_reset();
        hits(2'd0, 300);
        read_const("saturate", 2'd0, 255);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        read_const("tick_halve", 2'd0, 127);
        step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        read_const("hit_with_tick", 2'd0, 64);
        step(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        read_const("fill_with_tick", 2'd0, 1);
        check_counts("aging_counts");

        // Plain victim selection.
        set_counts(9, 4, 7, 4);
        check_counts("sel_counts");
        search("select", 1);

        // Fill of way 2 while the scan is under way.
        set_counts(5, 6, 2, 8);
        c0 = cyc; p0 = pulse_cnt;
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        idle(4);
        check("scanfill_latency", last_valid_cyc - c0, WAYS);
        check("scanfill_way", {30'd0, victim_way}, 2);

        // Hits raise way 2 to 6 before it is visited.
        set_counts(5, 6, 2, 8);
        hits(2'd2, 2);
        c0 = cyc;
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        idle(4);
        read_const("scanhit_way2", 2'd2, 6);
        check("scanhit_latency", last_valid_cyc - c0, WAYS);
        check("scanhit_way", {30'd0, victim_way}, 0);

        // Request held high: results at cycles 4, 9, 14.
        set_counts(3, 1, 2, 2);
        c0 = cyc; p0 = pulse_cnt;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("b2b_pulses", pulse_cnt - p0, 3);
        check("b2b_last_cycle", last_valid_cyc - c0, 14);
        idle(6);
        check("b2b_no_extra", pulse_cnt - p0, 3);

        // Reset in cycle 2 of a search.
        set_counts(4, 3, 2, 1);
        p0 = pulse_cnt;
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        check("midrst_busy", {31'd0, busy}, 0);
        for (int w = 0; w < WAYS; w++) read_const("midrst_count", IDX_W'(w), 0);
        idle(6);
        check("midrst_no_pulse", pulse_cnt - p0, 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
